// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer for the orthogonal DDS.
// Ports: clk/rst, cfg_* descriptor (valid/ready), start/abort, dds_en/
// dds_freq/dds_phase to the DDS, busy/done/step_idx/step_sync status.
module dds_sweep_ctrl #(
    parameter int PW  = 32,
    parameter int CW  = 16,
    parameter int LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_f_start,
    input  logic [PW-1:0] cfg_f_step,
    input  logic [CW-1:0] cfg_n_steps,
    input  logic [CW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [PW-1:0] cfg_phase,
    input  logic          start,
    input  logic          abort,
    output logic          dds_en,
    output logic [PW-1:0] dds_freq,
    output logic [PW-1:0] dds_phase,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step_idx,
    output logic          step_sync
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [1:0] M_REPEAT = 2'd1;
    localparam logic [1:0] M_TRI    = 2'd2;

    state_t        state_q, state_n;
    logic [PW-1:0] f_start_q, f_step_q, phase_q;
    logic [CW-1:0] n_steps_q, dwell_q;
    logic [1:0]    mode_q;
    logic [PW-1:0] freq_q, freq_n;
    logic [CW-1:0] idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          down_q, down_n;
    logic          done_q, done_n;
    logic          fresh_q, fresh_n;
    logic [LAT-1:0] sync_pipe;

    logic          accept;
    logic [CW-1:0] n_last;
    logic [CW-1:0] dwell_last;
    logic          multi;
    logic          step_end;

    // Zero step count / dwell behave as one.
    assign n_last     = (n_steps_q == '0) ? '0 : n_steps_q - CW'(1);
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CW'(1);
    assign multi      = (n_last != '0);
    assign step_end   = (cnt_q == dwell_last);

    assign cfg_ready = (state_q != RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state_q == RUN);
    assign dds_en    = busy;
    assign dds_freq  = freq_q;
    assign dds_phase = phase_q;
    assign step_idx  = idx_q;
    assign done      = done_q;
    assign step_sync = sync_pipe[LAT-1];

    always_comb begin
        state_n = state_q;
        freq_n  = freq_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        down_n  = down_q;
        done_n  = 1'b0;
        fresh_n = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_n = ARMED;
            end
            ARMED: begin
                // A descriptor arriving with start takes precedence.
                if (!accept && start) begin
                    state_n = RUN;
                    freq_n  = f_start_q;
                    idx_n   = '0;
                    cnt_n   = '0;
                    down_n  = 1'b0;
                    fresh_n = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = ARMED;
                end else if (!step_end) begin
                    cnt_n = cnt_q + CW'(1);
                end else begin
                    cnt_n = '0;
                    if (!down_q) begin
                        if (idx_q != n_last) begin
                            idx_n   = idx_q + CW'(1);
                            freq_n  = freq_q + f_step_q;
                            fresh_n = 1'b1;
                        end else if (mode_q == M_REPEAT) begin
                            if (multi) begin
                                idx_n   = '0;
                                freq_n  = f_start_q;
                                fresh_n = 1'b1;
                            end
                        end else if (mode_q == M_TRI) begin
                            if (multi) begin
                                down_n  = 1'b1;
                                idx_n   = idx_q - CW'(1);
                                freq_n  = freq_q - f_step_q;
                                fresh_n = 1'b1;
                            end
                        end else begin
                            state_n = ARMED;
                            done_n  = 1'b1;
                        end
                    end else if (idx_q != '0) begin
                        idx_n   = idx_q - CW'(1);
                        freq_n  = freq_q - f_step_q;
                        fresh_n = 1'b1;
                    end else begin
                        // Bottom endpoint: turn around without re-dwelling.
                        down_n  = 1'b0;
                        idx_n   = idx_q + CW'(1);
                        freq_n  = freq_q + f_step_q;
                        fresh_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            f_start_q <= '0;
            f_step_q  <= '0;
            n_steps_q <= '0;
            dwell_q   <= '0;
            mode_q    <= '0;
            phase_q   <= '0;
            freq_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            down_q    <= 1'b0;
            done_q    <= 1'b0;
            fresh_q   <= 1'b0;
            sync_pipe <= '0;
        end else begin
            state_q <= state_n;
            freq_q  <= freq_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            down_q  <= down_n;
            done_q  <= done_n;
            fresh_q <= fresh_n;
            if (accept) begin
                f_start_q <= cfg_f_start;
                f_step_q  <= cfg_f_step;
                n_steps_q <= cfg_n_steps;
                dwell_q   <= cfg_dwell;
                mode_q    <= cfg_mode;
                phase_q   <= cfg_phase;
            end
            // Tracks the DDS pipeline, which only advances when enabled;
            // the output stage is cleared so step_sync stays a pulse.
            if (dds_en) begin
                sync_pipe <= (sync_pipe << 1) | LAT'(fresh_q);
            end else begin
                sync_pipe[LAT-1] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus
// randomized descriptors against a closed-form sweep model.
module tb_dds_sweep_ctrl;

    localparam int PW  = 32;
    localparam int CW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [PW-1:0] cfg_f_start = '0;
    logic [PW-1:0] cfg_f_step = '0;
    logic [CW-1:0] cfg_n_steps = '0;
    logic [CW-1:0] cfg_dwell = '0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_phase = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dds_en;
    logic [PW-1:0] dds_freq;
    logic [PW-1:0] dds_phase;
    logic          busy;
    logic          done;
    logic [CW-1:0] step_idx;
    logic          step_sync;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_f, m_s;
    int          m_n, m_d, m_mode;

    dds_sweep_ctrl #(.PW(PW), .CW(CW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step),
        .cfg_n_steps(cfg_n_steps), .cfg_dwell(cfg_dwell),
        .cfg_mode(cfg_mode), .cfg_phase(cfg_phase),
        .start(start), .abort(abort),
        .dds_en(dds_en), .dds_freq(dds_freq), .dds_phase(dds_phase),
        .busy(busy), .done(done), .step_idx(step_idx),
        .step_sync(step_sync)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Step index seen on RUN cycle c (c = 0 is the first RUN cycle).
    function automatic int m_idx(input int c);
        int n = eff(m_n);
        int k = c / eff(m_d);
        int p;
        if (n == 1) return 0;
        if (m_mode == 1) return k % n;
        if (m_mode == 2) begin
            p = k % (2 * n - 2);
            return (p < n) ? p : (2 * n - 2 - p);
        end
        return (k < n) ? k : n - 1;
    endfunction

    function automatic logic [31:0] m_freq(input int c);
        logic [31:0] i;
        i = 32'(m_idx(c));
        return m_f + i * m_s;
    endfunction

    // True when RUN cycle c presents a new frequency.
    function automatic logic m_new(input int c);
        if (c < 0) return 1'b0;
        if (c == 0) return 1'b1;
        return (c % eff(m_d) == 0) && (eff(m_n) > 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] s,
                       input int n, input int d, input int mode,
                       input logic [31:0] ph);
        cfg_f_start = f;
        cfg_f_step  = s;
        cfg_n_steps = 16'(n);
        cfg_dwell   = 16'(d);
        cfg_mode    = 2'(mode);
        cfg_phase   = ph;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        m_f = f;
        m_s = s;
        m_n = n;
        m_d = d;
        m_mode = mode;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({cfg_ready, busy, dds_en, done, step_sync, dds_freq, dds_phase,
             step_idx} !== {1'b1, 4'b0, 32'd0, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b busy=%b en=%b done=%b sync=%b f=%h ph=%h idx=%0d, want rdy=1 rest 0",
                     cfg_ready, busy, dds_en, done, step_sync, dds_freq,
                     dds_phase, step_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_start_idle();
        go();
        tick();
        n_checks++;
        if ({busy, dds_en, cfg_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL start_idle: busy=%b en=%b rdy=%b, want 0 0 1",
                     busy, dds_en, cfg_ready);
        end
    endtask

    task automatic test_oneshot();
        int pulses = 0;
        cfg(32'd1000, 32'd100, 4, 3, 0, 32'h1234);
        n_checks++;
        if ({dds_phase, cfg_ready, busy} !== {32'h1234, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL oneshot_cfg: ph=%h rdy=%b busy=%b, want 1234 1 0",
                     dds_phase, cfg_ready, busy);
        end
        go();
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if ({dds_en, busy, done, dds_freq, step_idx} !==
                {3'b110, m_freq(c), 16'(m_idx(c))}) begin
                n_fail++;
                $display("FAIL oneshot c=%0d: en=%b busy=%b done=%b f=%0d idx=%0d, want f=%0d idx=%0d",
                         c, dds_en, busy, done, dds_freq, step_idx,
                         m_freq(c), m_idx(c));
            end
            n_checks++;
            if (step_sync !== m_new(c - LAT)) begin
                n_fail++;
                $display("FAIL oneshot_sync c=%0d: got %b want %b",
                         c, step_sync, m_new(c - LAT));
            end
            pulses += int'(step_sync);
            tick();
        end
        pulses += int'(step_sync);
        n_checks++;
        if ({done, dds_en, busy, step_sync, dds_freq, step_idx} !==
            {4'b1001, 32'd1300, 16'd3}) begin
            n_fail++;
            $display("FAIL oneshot_end: done=%b en=%b busy=%b sync=%b f=%0d idx=%0d, want 1 0 0 1 1300 3",
                     done, dds_en, busy, step_sync, dds_freq, step_idx);
        end
        tick();
        n_checks++;
        if ({done, step_sync, cfg_ready, dds_freq} !== {3'b001, 32'd1300}) begin
            n_fail++;
            $display("FAIL oneshot_after: done=%b sync=%b rdy=%b f=%0d, want 0 0 1 1300",
                     done, step_sync, cfg_ready, dds_freq);
        end
        n_checks++;
        if (pulses !== 4) begin
            n_fail++;
            $display("FAIL oneshot_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_abort();
        cfg(32'd1000, 32'd100, 4, 3, 0, 32'h0);
        go();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({busy, dds_freq, step_idx} !== {1'b1, m_freq(c), 16'(m_idx(c))}) begin
                n_fail++;
                $display("FAIL abort_run c=%0d: busy=%b f=%0d idx=%0d, want f=%0d",
                         c, busy, dds_freq, step_idx, m_freq(c));
            end
            if (c == 4) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        n_checks++;
        if ({busy, dds_en, done, cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_stop: busy=%b en=%b done=%b rdy=%b, want 0 0 0 1",
                     busy, dds_en, done, cfg_ready);
        end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_nodone: done=%b busy=%b, want 0 0", done, busy);
        end
        go();
        n_checks++;
        if ({busy, dds_freq, step_idx} !== {1'b1, 32'd1000, 16'd0}) begin
            n_fail++;
            $display("FAIL abort_restart: busy=%b f=%0d idx=%0d, want 1 1000 0",
                     busy, dds_freq, step_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_repeat();
        cfg(32'd0, 32'd100, 3, 1, 1, 32'h0);
        go();
        for (int c = 0; c < 10; c++) begin
            cfg_valid   = (c >= 2 && c <= 4);
            cfg_f_start = 32'd5555;
            n_checks++;
            if ({busy, cfg_ready, dds_freq, step_idx} !==
                {2'b10, m_freq(c), 16'(m_idx(c))}) begin
                n_fail++;
                $display("FAIL repeat c=%0d: busy=%b rdy=%b f=%0d idx=%0d, want f=%0d idx=%0d",
                         c, busy, cfg_ready, dds_freq, step_idx,
                         m_freq(c), m_idx(c));
            end
            tick();
        end
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        go();
        n_checks++;
        if (dds_freq !== 32'd0) begin
            n_fail++;
            $display("FAIL run_cfg_ignored: f=%0d want 0", dds_freq);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_triangle();
        cfg(32'd0, 32'd100, 3, 1, 2, 32'h0);
        go();
        for (int c = 0; c < 14; c++) begin
            n_checks++;
            if ({busy, dds_freq, step_idx} !== {1'b1, m_freq(c), 16'(m_idx(c))}) begin
                n_fail++;
                $display("FAIL triangle c=%0d: f=%0d idx=%0d, want f=%0d idx=%0d",
                         c, dds_freq, step_idx, m_freq(c), m_idx(c));
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_wrap();
        cfg(32'h10, 32'hFFFF_FFE0, 2, 1, 0, 32'h0);
        go();
        n_checks++;
        if (dds_freq !== 32'h10) begin
            n_fail++;
            $display("FAIL wrap_0: f=%h want 00000010", dds_freq);
        end
        tick();
        n_checks++;
        if ({dds_freq, step_idx} !== {32'hFFFF_FFF0, 16'd1}) begin
            n_fail++;
            $display("FAIL wrap_1: f=%h idx=%0d want fffffff0 1", dds_freq, step_idx);
        end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_cfg_start_same();
        cfg_f_start = 32'd777;
        cfg_f_step  = 32'd1;
        cfg_n_steps = 16'd2;
        cfg_dwell   = 16'd2;
        cfg_mode    = 2'd0;
        cfg_phase   = 32'hABCD;
        cfg_valid   = 1'b1;
        start       = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_checks++;
        if ({busy, dds_en, dds_phase} !== {2'b00, 32'hABCD}) begin
            n_fail++;
            $display("FAIL cfg_start: busy=%b en=%b ph=%h, want 0 0 abcd",
                     busy, dds_en, dds_phase);
        end
        go();
        n_checks++;
        if ({busy, dds_freq} !== {1'b1, 32'd777}) begin
            n_fail++;
            $display("FAIL cfg_start_go: busy=%b f=%0d, want 1 777", busy, dds_freq);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_degenerate();
        cfg(32'd500, 32'd7, 0, 0, 0, 32'h0);
        go();
        n_checks++;
        if ({busy, done, dds_freq, step_idx} !== {2'b10, 32'd500, 16'd0}) begin
            n_fail++;
            $display("FAIL degen_run: busy=%b done=%b f=%0d idx=%0d, want 1 0 500 0",
                     busy, done, dds_freq, step_idx);
        end
        tick();
        n_checks++;
        if ({busy, dds_en, done, dds_freq} !== {3'b001, 32'd500}) begin
            n_fail++;
            $display("FAIL degen_done: busy=%b en=%b done=%b f=%0d, want 0 0 1 500",
                     busy, dds_en, done, dds_freq);
        end
    endtask

    task automatic test_reset_mid();
        cfg(32'd1000, 32'd100, 4, 3, 0, 32'h55);
        go();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({cfg_ready, busy, dds_en, done, step_sync, dds_freq, dds_phase,
             step_idx} !== {1'b1, 4'b0, 32'd0, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b busy=%b en=%b done=%b sync=%b f=%0d ph=%h idx=%0d, want 1 and zeros",
                     cfg_ready, busy, dds_en, done, step_sync, dds_freq,
                     dds_phase, step_idx);
        end
        rst = 1'b0;
        go();
        n_checks++;
        if ({busy, dds_en, cfg_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy=%b en=%b rdy=%b, want 0 0 1",
                     busy, dds_en, cfg_ready);
        end
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 10; t++) begin
            do_reset();
            cfg($urandom, $urandom, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                $urandom);
            go();
            len = (m_mode == 1 || m_mode == 2) ? 24 : eff(m_n) * eff(m_d);
            for (int c = 0; c < len; c++) begin
                n_checks++;
                if ({busy, dds_en, done, step_sync, dds_freq, step_idx} !==
                    {3'b110, m_new(c - LAT), m_freq(c), 16'(m_idx(c))}) begin
                    n_fail++;
                    $display("FAIL random t=%0d mode=%0d n=%0d d=%0d c=%0d: busy=%b done=%b sync=%b f=%h idx=%0d, want sync=%b f=%h idx=%0d",
                             t, m_mode, m_n, m_d, c, busy, done, step_sync,
                             dds_freq, step_idx, m_new(c - LAT), m_freq(c),
                             m_idx(c));
                end
                tick();
            end
            if (m_mode == 1 || m_mode == 2) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                n_checks++;
                if ({busy, done} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL random_abort t=%0d: busy=%b done=%b want 0 0",
                             t, busy, done);
                end
            end else begin
                n_checks++;
                if ({busy, done, step_sync, dds_freq} !==
                    {2'b01, m_new(len - LAT), m_freq(len - 1)}) begin
                    n_fail++;
                    $display("FAIL random_end t=%0d: busy=%b done=%b sync=%b f=%h, want 0 1 %b %h",
                             t, busy, done, step_sync, dds_freq,
                             m_new(len - LAT), m_freq(len - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_idle();
        test_oneshot();
        test_abort();
        test_repeat();
        test_triangle();
        test_wrap();
        test_cfg_start_same();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the frequency/phase/enable inputs of the orthogonal DDS to produce stepped linear frequency sweeps for FM test and calibration.
- Accepts a sweep descriptor over a valid/ready handshake and runs it on `start`.
- Steps the tuning word through N frequencies, dwelling a programmable number of cycles on each.
- Supports one-shot, repeat and triangle (up/down) modes.
- Emits step-sync pulses delayed to line up with the DDS output samples.

Parameters:
- PW, 32, phase/tuning word width; must match the DDS.
- CW, 16, width of step-count and dwell counters.
- LAT, 3, DDS latency from freq input change to sin/cos output change, in enabled cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready
- cfg_f_start  in  PW  first tuning word (unsigned, modulo 2^PW)
- cfg_f_step  in  PW  signed tuning-word increment per step
- cfg_n_steps  in  CW  number of frequency steps; 0 is treated as 1
- cfg_dwell  in  CW  cycles per step; 0 is treated as 1
- cfg_mode  in  2  0 = oneshot, 1 = repeat, 2 = triangle, 3 = reserved (behaves as oneshot)
- cfg_phase  in  PW  phase offset forwarded to the DDS
- start  in  1  begin sweep (ARMED only)
- abort  in  1  stop sweep (RUN only)
- dds_en  out  1  DDS enable
- dds_freq  out  PW  DDS tuning word
- dds_phase  out  PW  DDS phase offset
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at oneshot completion
- step_idx  out  CW  current step index
- step_sync  out  1  pulse when a new step's frequency reaches the DDS output

Behaviour:
- Reset: state IDLE; all outputs 0, except cfg_ready = 1. Delay line for step_sync cleared.
- FSM states: IDLE, ARMED, RUN.
- cfg_ready is 1 in IDLE and ARMED, and 0 in RUN.
- Config acceptance: latches all cfg_* fields. dds_phase updates on the next cycle. State becomes ARMED.
- Start handling:
  - In IDLE, start is ignored.
  - In ARMED, if cfg accept and start occur in the same cycle, the config wins and start is ignored.
- Start in ARMED at cycle t:
  - At t+1: state RUN, dds_en = 1, dds_freq = f_start, step_idx = 0, dwell counter = 0, direction = up.
- RUN cycle accounting:
  - Each step holds for exactly max(dwell,1) cycles.
  - On the last cycle of a step, the next-step logic applies.
- Next-step logic (n = max(n_steps,1)):
  - Up, idx < n−1: idx+1, freq += step.
  - Up, idx == n−1, oneshot: state ARMED at next cycle, dds_en = 0, done pulses that cycle, dds_freq/step_idx hold last values.
  - Up, idx == n−1, repeat: idx = 0, freq = f_start.
  - Up, idx == n−1, triangle, n > 1: direction down, idx−1, freq −= step.
  - Down, idx > 0: idx−1, freq −= step. At idx == 0, direction up, idx+1, freq += step.
  - Triangle endpoints are dwelt once per pass, not twice. With n == 1 in triangle or repeat, the single frequency is held indefinitely.
- Arithmetic: freq updated by add/subtract of the step, modulo 2^PW (wraps, no saturation). No multiplier.
- abort in RUN:
  - Abort has priority over step logic.
  - Next cycle: ARMED, dds_en = 0, busy = 0, no done pulse.
  - A later start restarts from f_start, idx 0.
  - abort outside RUN is ignored.
- step_sync:
  - An internal pulse fires on every cycle RUN presents a new frequency, including the first cycle after start.
  - It is delayed through LAT register stages that shift only while dds_en = 1, so it coincides with the first DDS output sample of that step.
- Reset mid-operation returns everything to reset values within one cycle.
- busy = (state == RUN).

Test Plan:
- Oneshot: f_start=1000, step=100, n=4, dwell=3, start → dds_freq 1000,1000,1000,1100×3,1200×3,1300×3 (12 RUN cycles).
  - Then done=1 for one cycle, dds_en=0, dds_freq held 1300, busy=0.
  - step_sync pulses 4 times, each LAT=3 enabled cycles after the freq change.
- Repeat/triangle: n=3, dwell=1, step=100, f_start=0.
  - Repeat: 0,100,200,0,100,…
  - Triangle: 0,100,200,100,0,100,200…, with step_idx 0,1,2,1,0,1,2.
- Wrap/negative step: f_start=0x00000010, step=0xFFFFFFE0 (−32), n=2, dwell=1 → 0x00000010 then 0xFFFFFFF0.
- Abort and restart: abort on 5th RUN cycle of scenario 1 → next cycle ARMED, dds_en=0, no done. Restart gives dds_freq=1000, step_idx=0.
- Handshake edges:
  - cfg_valid during RUN: not accepted (cfg_ready=0).
  - cfg_valid+start together in ARMED: new config latched, start ignored.
  - start in IDLE: ignored.
- Degenerate/reset: n=0, dwell=0 oneshot → one RUN cycle at f_start, then done. rst asserted mid-RUN → next cycle all outputs 0, cfg_ready=1.
